// File: rtl/pc_fetch.sv
// Program-counter / instruction-fetch stage of the single-cycle RV32I core.
// Fetches one instruction over a req/ready handshake, holds it for decode until
// it retires, then advances the PC (PC+4 or PC+immOp on a taken branch).
// Optional build macro: PC_ALIGN_CHECK_EN -- traps word-misaligned branch
// targets (pc held, misaligned raised, fetch halted). Default build loads the
// target unchanged and ties misaligned low.
module pc_fetch #(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] immOp,
  input  logic                  stall,
  input  logic                  halt,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  misaligned
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  instr_valid_q;
  logic                  imem_req_q;
  logic                  halted_q;
  logic                  misaligned_q;

  logic [DATA_WIDTH-1:0] pc_seq;
  logic [DATA_WIDTH-1:0] pc_br;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  br_trap;

  // Both adds wrap modulo 2^DATA_WIDTH; immOp is already sign-extended.
  always_comb begin
    pc_seq  = pc_q + DATA_WIDTH'(4);
    pc_br   = pc_q + immOp;
    pc_next = PCsrc ? pc_br : pc_seq;
  end

`ifdef PC_ALIGN_CHECK_EN
  // Only taken branches are checked; PC+4 from an aligned PC stays aligned.
  assign br_trap = PCsrc && (pc_br[1:0] != 2'b00);
`else
  assign br_trap = 1'b0;
`endif

  // Fetch FSM; all outputs are registered so memory sees a glitch-free request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          // Request and address stay put until memory answers.
          if (imem_ready) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= StExec;
          end
        end
        StExec: begin
          // stall has priority over halt; halt is only looked at on retire.
          if (!stall) begin
            instr_valid_q <= 1'b0;
            if (br_trap) begin
              misaligned_q <= 1'b1;
              halted_q     <= 1'b1;
              state_q      <= StHalt;
            end else begin
              pc_q <= pc_next;
              if (halt) begin
                halted_q <= 1'b1;
                state_q  <= StHalt;
              end else begin
                imem_req_q <= 1'b1;
                state_q    <= StFetch;
              end
            end
          end
        end
        StHalt: begin
          // Sticky until reset.
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a directed vector table, hand-written
// multi-cycle sequences (wrap, async reset mid-fetch, misaligned branch), and
// randomized stimulus against a behavioural model. Honours PC_ALIGN_CHECK_EN.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] immOp = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        halted;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  pc_fetch #(
    .DATA_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCsrc      (PCsrc),
    .immOp      (immOp),
    .stall      (stall),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .halted     (halted),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        stl;
    logic        src;
    logic [31:0] imm;
    logic        hlt;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_halted;
  } vec_t;

  vec_t tbl[24];

  // Behavioural model state
  bit          m_started, m_has, m_halted, m_mis;
  logic [31:0] m_pc, m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_pc,
                           input logic e_valid, input logic [31:0] e_instr,
                           input logic e_halted, input logic e_mis);
    chk({tag, ".imem_req"}, 32'(imem_req), 32'(e_req));
    chk({tag, ".imem_addr"}, imem_addr, e_pc);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".halted"}, 32'(halted), 32'(e_halted));
    chk({tag, ".misaligned"}, 32'(misaligned), 32'(e_mis));
  endtask

  task automatic drive(input logic r, input logic [31:0] d, input logic s, input logic p,
                       input logic [31:0] i, input logic h);
    imem_ready = r;
    imem_rdata = d;
    stall      = s;
    PCsrc      = p;
    immOp      = i;
    halt       = h;
  endtask

  // Drive for one clock and return at the following falling edge.
  task automatic cyc(input logic r, input logic [31:0] d, input logic s, input logic p,
                     input logic [31:0] i, input logic h);
    drive(r, d, s, p, i, h);
    @(negedge clk);
  endtask

  // Returns at a falling edge with rst released; the DUT is in its idle state.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  function automatic vec_t v(input logic r, input logic [31:0] d, input logic s, input logic p,
                             input logic [31:0] i, input logic h, input logic e_req,
                             input logic [31:0] e_pc, input logic e_valid,
                             input logic [31:0] e_instr, input logic e_halted);
    vec_t x;
    x.ready = r; x.rdata = d; x.stl = s; x.src = p; x.imm = i; x.hlt = h;
    x.e_req = e_req; x.e_pc = e_pc; x.e_valid = e_valid; x.e_instr = e_instr;
    x.e_halted = e_halted;
    return x;
  endfunction

  function automatic void model_reset();
    m_started = 0; m_has = 0; m_halted = 0; m_mis = 0;
    m_pc = 32'h0; m_instr = 32'h0;
  endfunction

  // One rising edge of the fetch unit, straight from the stage's rules.
  function automatic void model_edge();
    logic [31:0] target;
    if (!m_started) begin
      m_started = 1;
    end else if (m_halted) begin
      // stopped
    end else if (!m_has) begin
      if (imem_ready) begin
        m_instr = imem_rdata;
        m_has   = 1;
      end
    end else if (!stall) begin
      target = PCsrc ? m_pc + immOp : m_pc + 32'd4;
      m_has  = 0;
      if (AlignChk && PCsrc && (target % 4 != 0)) begin
        m_mis    = 1;
        m_halted = 1;
      end else begin
        m_pc = target;
        if (halt) m_halted = 1;
      end
    end
  endfunction

  initial begin
    logic [31:0] imm;

    // ready, rdata, stall, PCsrc, immOp, halt -> req, pc, valid, instr, halted
    tbl[0]  = v(1, 32'hAA, 0, 0, 0, 0,             1, 32'h00, 0, 32'h00, 0);
    tbl[1]  = v(1, 32'h11, 0, 0, 0, 0,             0, 32'h00, 1, 32'h11, 0);
    tbl[2]  = v(0, 32'h00, 0, 0, 0, 0,             1, 32'h04, 0, 32'h11, 0);
    tbl[3]  = v(1, 32'h22, 0, 0, 0, 0,             0, 32'h04, 1, 32'h22, 0);
    tbl[4]  = v(0, 32'h00, 0, 0, 0, 0,             1, 32'h08, 0, 32'h22, 0);
    tbl[5]  = v(1, 32'h33, 0, 0, 0, 0,             0, 32'h08, 1, 32'h33, 0);
    tbl[6]  = v(0, 32'h00, 0, 0, 0, 0,             1, 32'h0C, 0, 32'h33, 0);
    tbl[7]  = v(1, 32'h44, 0, 0, 0, 0,             0, 32'h0C, 1, 32'h44, 0);
    tbl[8]  = v(0, 32'h00, 0, 0, 0, 0,             1, 32'h10, 0, 32'h44, 0);
    tbl[9]  = v(1, 32'h55, 0, 0, 0, 0,             0, 32'h10, 1, 32'h55, 0);
    tbl[10] = v(0, 32'h00, 0, 1, 32'hFFFF_FFF8, 0, 1, 32'h08, 0, 32'h55, 0);
    tbl[11] = v(1, 32'h66, 0, 0, 0, 0,             0, 32'h08, 1, 32'h66, 0);
    tbl[12] = v(0, 32'h00, 0, 1, 32'h28, 0,        1, 32'h30, 0, 32'h66, 0);
    tbl[13] = v(0, 32'h00, 0, 0, 0, 1,             1, 32'h30, 0, 32'h66, 0);
    tbl[14] = v(0, 32'h00, 0, 0, 0, 1,             1, 32'h30, 0, 32'h66, 0);
    tbl[15] = v(0, 32'h00, 0, 0, 0, 0,             1, 32'h30, 0, 32'h66, 0);
    tbl[16] = v(1, 32'h77, 0, 0, 0, 0,             0, 32'h30, 1, 32'h77, 0);
    for (int k = 17; k < 22; k++)
      tbl[k] = v(1, 32'h99, 1, 1, 32'h100, 1,      0, 32'h30, 1, 32'h77, 0);
    tbl[22] = v(0, 32'h00, 0, 0, 0, 1,             0, 32'h34, 0, 32'h77, 1);
    tbl[23] = v(1, 32'h88, 0, 0, 0, 0,             0, 32'h34, 0, 32'h77, 1);

    do_reset();
    for (int k = 0; k < 24; k++) begin
      cyc(tbl[k].ready, tbl[k].rdata, tbl[k].stl, tbl[k].src, tbl[k].imm, tbl[k].hlt);
      check_all($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_pc, tbl[k].e_valid,
                tbl[k].e_instr, tbl[k].e_halted, 1'b0);
    end

    // PC wraps modulo 2^32
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h1234, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap.branch", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 32'h5678, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap.seq", imem_addr, 32'h0);
    chk("wrap.req", 32'(imem_req), 32'd1);

    // Asynchronous reset while a fetch is outstanding at 0x40
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h13, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h40, 0);
    chk("arst.pre_pc", pc, 32'h40);
    chk("arst.pre_req", 32'(imem_req), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1 check_all("arst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Branch to a non-word-aligned target
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 32'h21, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h20, 0);
    cyc(1, 32'h31, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h6, 0);
    if (AlignChk) check_all("misal", 1'b0, 32'h20, 1'b0, 32'h31, 1'b1, 1'b1);
    else          check_all("misal", 1'b1, 32'h26, 1'b0, 32'h31, 1'b0, 1'b0);

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if (m_halted && $urandom_range(3) == 0) begin
        do_reset();
        model_reset();
      end
      imm = 32'($urandom_range(64)) << 2;
      if ($urandom_range(1) == 1) imm = -imm;
      if ($urandom_range(7) == 0) imm = imm | 32'($urandom_range(3));
      drive($urandom_range(1) == 1, $urandom, $urandom_range(2) == 0,
            $urandom_range(1) == 1, imm, $urandom_range(15) == 0);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all("rnd", m_started && !m_has && !m_halted, m_pc, m_has, m_instr, m_halted, m_mis);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
